// File: rtl/ldmac_key_pkg.sv
// ldmac_key_pkg: shared widths, rotation constants and FSM states for the LDMAC key schedule
package ldmac_key_pkg;
   localparam int KEY_W  = 128;
   localparam int WORD_W = 32;
   localparam int HALF_W = WORD_W / 2;
   localparam int LO_ROT = 4;
   localparam int HI_ROT = 2;
   typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_e;
endpackage

// File: rtl/key_update_inv.sv
// key_update_inv: one combinational inverse key-schedule step (pure wiring)
//   key     : round key K_i = {w3,w2,w1,w0}
//   inv_key : K_{i-1} = {w2,w1,w0,p}; p.lo = rotr(w3.lo,LO_ROT), p.hi = rotl(w3.hi,HI_ROT)
module key_update_inv
   import ldmac_key_pkg::*;
(
   input  logic [KEY_W-1:0] key,
   output logic [KEY_W-1:0] inv_key
);
   logic [WORD_W-1:0] w3;
   logic [HALF_W-1:0] lo;
   logic [HALF_W-1:0] hi;
   assign w3 = key[KEY_W-1 -: WORD_W];
   assign lo = w3[HALF_W-1:0];
   assign hi = w3[WORD_W-1:HALF_W];
   assign inv_key = {key[KEY_W-WORD_W-1:0],
                     hi[HALF_W-HI_ROT-1:0], hi[HALF_W-1 -: HI_ROT],
                     lo[LO_ROT-1:0], lo[HALF_W-1:LO_ROT]};
endmodule

// File: rtl/key_update_inv_stream.sv
// key_update_inv_stream: loads K_N and N, then streams K_N..K_0 over valid/ready
//   in_valid/in_ready/in_key/in_rounds : load handshake (ready only while idle)
//   out_valid/out_ready/out_key/out_idx/out_last : round-key stream, last when idx==0
//   abort : synchronous cancel back to idle, wins over any handshake
//   done  : one-cycle pulse after K_0 is accepted
module key_update_inv_stream #(
   parameter int KEY_W = 128,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [KEY_W-1:0] in_key,
   input  logic [CNT_W-1:0] in_rounds,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [KEY_W-1:0] out_key,
   output logic [CNT_W-1:0] out_idx,
   output logic             out_last,
   input  logic             abort,
   output logic             done
);
   import ldmac_key_pkg::*;
   state_e           state;
   logic [KEY_W-1:0] key_q;
   logic [KEY_W-1:0] inv_key;
   logic [CNT_W-1:0] cnt_q;
   logic             last_q;
   logic             done_q;
   key_update_inv u_inv (.key(key_q), .inv_key(inv_key));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         key_q  <= '0;
         cnt_q  <= '0;
         last_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            state <= IDLE;
         end else if (state == IDLE) begin
            if (in_valid) begin
               state  <= EMIT;
               key_q  <= in_key;
               cnt_q  <= in_rounds;
               last_q <= in_rounds == '0;
            end
         end else if (out_ready) begin
            if (cnt_q == '0) begin
               state  <= IDLE;
               done_q <= 1'b1;
            end else begin
               key_q  <= inv_key;
               cnt_q  <= cnt_q - CNT_W'(1);
               last_q <= cnt_q == CNT_W'(1);
            end
         end
      end
   end
   assign in_ready  = state == IDLE;
   assign out_valid = state == EMIT;
   assign out_key   = key_q;
   assign out_idx   = cnt_q;
   assign out_last  = last_q;
   assign done      = done_q;
endmodule
